// File: rtl/obj_frame_renderer_if.sv
// obj_frame_renderer_if: packed object bus from the manipulator and pixel bus to the VGA adapter
interface obj_frame_renderer_if;
    logic [179:0] objCoordcomb;
    logic         imagedone;
    logic [8:0]   vga_x;
    logic [7:0]   vga_y;
    logic [2:0]   vga_colour;
    logic         vga_plot;
    modport master (output objCoordcomb, imagedone, input vga_x, vga_y, vga_colour, vga_plot);
    modport slave (input objCoordcomb, imagedone, output vga_x, vga_y, vga_colour, vga_plot);
endinterface

// File: rtl/obj_frame_renderer.sv
// obj_frame_renderer: per frame, erases old squares, draws new ones and checks them against the player box
module obj_frame_renderer #(
    parameter int         OBJ_SIZE    = 4,
    parameter int         PLAYER_SIZE = 16,
    parameter logic [2:0] OBJ_COLOUR  = 3'b100,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    obj_frame_renderer_if.slave        bus,
    input  logic [8:0]                 playerX,
    input  logic [7:0]                 playerY,
    input  logic                       clear_collision,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       collision
);
    localparam int PW = (OBJ_SIZE > 1) ? $clog2(OBJ_SIZE) : 1;
    localparam logic [9:0] OS = 10'(OBJ_SIZE);
    localparam logic [9:0] PS = 10'(PLAYER_SIZE);
    typedef enum logic [2:0] {IDLE, ERASE, DRAW, CHECK, DONE} state_t;
    state_t state, state_n;
    logic [179:0] old_q, new_q;
    logic imagedone_q, rise, last_pix, overlap, plot_n, walking;
    logic [3:0] slot, slot_n;
    logic [PW-1:0] px, py, px_n, py_n;
    logic [17:0] obj;
    logic [9:0] ox, oy, sx, sy, plx, ply;
    assign busy = state != IDLE;
    always_comb begin
        rise = bus.imagedone & ~imagedone_q;
        walking = state == ERASE || state == DRAW;
        obj = (state == ERASE) ? old_q[{4'd0, slot} * 8'd18 +: 18] : new_q[{4'd0, slot} * 8'd18 +: 18];
        ox = {1'b0, obj[8:0]};
        oy = {2'b0, obj[16:9]};
        sx = ox + 10'(px);
        sy = oy + 10'(py);
        plx = {1'b0, playerX};
        ply = {2'b0, playerY};
        overlap = obj[17] && ox < plx + PS && plx < ox + OS && oy < ply + PS && ply < oy + OS;
        // power-of-two size makes "last pixel" an all-ones test
        last_pix = !obj[17] || (&px && &py);
        plot_n = walking && obj[17] && sx < 10'd320 && sy < 10'd240;
        state_n = state;
        slot_n = slot;
        px_n = px;
        py_n = py;
        if (state == IDLE && rise) begin
            state_n = ERASE;
            slot_n = '0;
            px_n = '0;
            py_n = '0;
        end else if (walking) begin
            px_n = last_pix ? '0 : px + 1'b1;
            py_n = last_pix ? '0 : (&px ? py + 1'b1 : py);
            slot_n = !last_pix ? slot : (slot == 4'd9 ? 4'd0 : slot + 4'd1);
            if (last_pix && slot == 4'd9)
                state_n = (state == ERASE) ? DRAW : CHECK;
        end else if (state == CHECK) begin
            slot_n = (slot == 4'd9) ? 4'd0 : slot + 4'd1;
            if (slot == 4'd9)
                state_n = DONE;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            slot <= '0;
            px <= '0;
            py <= '0;
            old_q <= '0;
            new_q <= '0;
            imagedone_q <= 1'b0;
            bus.vga_plot <= 1'b0;
            bus.vga_x <= '0;
            bus.vga_y <= '0;
            bus.vga_colour <= '0;
            frame_done <= 1'b0;
            collision <= 1'b0;
        end else begin
            state <= state_n;
            slot <= slot_n;
            px <= px_n;
            py <= py_n;
            imagedone_q <= bus.imagedone;
            if (state == IDLE && rise)
                new_q <= bus.objCoordcomb;
            if (state == DONE)
                old_q <= new_q;
            bus.vga_plot <= plot_n;
            bus.vga_x <= sx[8:0];
            bus.vga_y <= sy[7:0];
            bus.vga_colour <= (state == DRAW) ? OBJ_COLOUR : BG_COLOUR;
            frame_done <= state == DONE;
            collision <= (state == CHECK && overlap) ? 1'b1 : (clear_collision ? 1'b0 : collision);
        end
    end
endmodule

// File: tb/tb_obj_frame_renderer.sv
// tb_obj_frame_renderer: directed frames checking plot streams, frame lengths, clipping and collision
module tb_obj_frame_renderer;
    logic CLOCK_50 = 1'b0;
    logic reset = 1'b0;
    logic clear_collision = 1'b0;
    logic [8:0] playerX = 9'd100;
    logic [7:0] playerY = 8'd100;
    logic busy, frame_done, collision;
    int checks = 0;
    int failures = 0;
    int cyc, first_plot;
    logic [8:0] xs[$];
    logic [7:0] ys[$];
    logic [2:0] cs[$];

    obj_frame_renderer_if bus();

    obj_frame_renderer dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus.slave),
        .playerX(playerX),
        .playerY(playerY),
        .clear_collision(clear_collision),
        .busy(busy),
        .frame_done(frame_done),
        .collision(collision)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [179:0] slot0(input logic [7:0] y, input logic [8:0] x);
        return {162'd0, 1'b1, y, x};
    endfunction

    task automatic frame(input logic [179:0] objs, input int inject, input logic [179:0] alt);
        xs.delete();
        ys.delete();
        cs.delete();
        cyc = 0;
        first_plot = 0;
        bus.objCoordcomb = objs;
        bus.imagedone = 1'b1;
        while (cyc < 2000) begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
            if (cyc == 3) bus.imagedone = 1'b0;
            if (cyc == inject) begin
                bus.objCoordcomb = alt;
                bus.imagedone = 1'b1;
            end
            if (cyc == inject + 2) bus.imagedone = 1'b0;
            if (bus.vga_plot) begin
                if (first_plot == 0) first_plot = cyc;
                xs.push_back(bus.vga_x);
                ys.push_back(bus.vga_y);
                cs.push_back(bus.vga_colour);
            end
            if (frame_done) break;
        end
        bus.imagedone = 1'b0;
    endtask

    task automatic test_reset;
        bus.imagedone = 1'b0;
        bus.objCoordcomb = '0;
        reset = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        checks++;
        if ({bus.vga_plot, busy, frame_done, collision} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.vga_plot, busy, frame_done, collision});
        end
        checks++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 20'd0) begin
            failures++;
            $display("FAIL reset_pixel got=%0d,%0d,%0d exp=0,0,0", bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic test_first_frame;
        frame(slot0(8'd10, 9'd20), -10, '0);
        checks++;
        if (cyc !== 47) begin
            failures++;
            $display("FAIL first_len got=%0d exp=47", cyc);
        end
        checks++;
        if (first_plot !== 12) begin
            failures++;
            $display("FAIL first_plot_cycle got=%0d exp=12", first_plot);
        end
        checks++;
        if (xs.size() !== 16) begin
            failures++;
            $display("FAIL first_count got=%0d exp=16", xs.size());
        end
        for (int i = 0; i < 16 && i < xs.size(); i++) begin
            checks++;
            if ({xs[i], ys[i], cs[i]} !== {9'(20 + i % 4), 8'(10 + i / 4), 3'b100}) begin
                failures++;
                $display("FAIL first_pix%0d got=%0d,%0d,%0d exp=%0d,%0d,4", i, xs[i], ys[i], cs[i], 20 + i % 4, 10 + i / 4);
            end
        end
    endtask

    task automatic test_move;
        frame(slot0(8'd10, 9'd21), -10, '0);
        checks++;
        if (cyc !== 62) begin
            failures++;
            $display("FAIL move_len got=%0d exp=62", cyc);
        end
        checks++;
        if (xs.size() !== 32) begin
            failures++;
            $display("FAIL move_count got=%0d exp=32", xs.size());
        end
        for (int i = 0; i < 32 && i < xs.size(); i++) begin
            checks++;
            if ({xs[i], ys[i], cs[i]} !== {9'((i < 16 ? 20 : 21) + i % 4), 8'(10 + (i % 16) / 4), (i < 16 ? 3'b000 : 3'b100)}) begin
                failures++;
                $display("FAIL move_pix%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", i, xs[i], ys[i], cs[i],
                         (i < 16 ? 20 : 21) + i % 4, 10 + (i % 16) / 4, i < 16 ? 0 : 4);
            end
        end
    endtask

    task automatic test_clip;
        logic [8:0] ex [4] = '{9'd318, 9'd319, 9'd318, 9'd319};
        logic [7:0] ey [4] = '{8'd238, 8'd238, 8'd239, 8'd239};
        frame(slot0(8'd238, 9'd318), -10, '0);
        checks++;
        if (cyc !== 62) begin
            failures++;
            $display("FAIL clip_len got=%0d exp=62", cyc);
        end
        checks++;
        if (xs.size() !== 20) begin
            failures++;
            $display("FAIL clip_count got=%0d exp=20", xs.size());
        end
        for (int i = 0; i < 4 && 16 + i < xs.size(); i++) begin
            checks++;
            if ({xs[16 + i], ys[16 + i], cs[16 + i]} !== {ex[i], ey[i], 3'b100}) begin
                failures++;
                $display("FAIL clip_pix%0d got=%0d,%0d,%0d exp=%0d,%0d,4", i, xs[16 + i], ys[16 + i], cs[16 + i], ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_collision;
        playerX = 9'd100;
        playerY = 8'd100;
        frame(slot0(8'd115, 9'd115), -10, '0);
        checks++;
        if (collision !== 1'b1) begin
            failures++;
            $display("FAIL coll_overlap got=%b exp=1", collision);
        end
        clear_collision = 1'b1;
        @(posedge CLOCK_50);
        #1;
        clear_collision = 1'b0;
        checks++;
        if (collision !== 1'b0) begin
            failures++;
            $display("FAIL coll_clear got=%b exp=0", collision);
        end
        frame(slot0(8'd100, 9'd116), -10, '0);
        checks++;
        if (collision !== 1'b0) begin
            failures++;
            $display("FAIL coll_edge got=%b exp=0", collision);
        end
    endtask

    task automatic test_disabled;
        logic [179:0] objs;
        for (int n = 0; n < 10; n++) objs[n * 18 +: 18] = {1'b0, 8'(50 + n), 9'(60 + n)};
        frame(objs, -10, '0);
        checks++;
        if (cyc !== 47 || xs.size() !== 16) begin
            failures++;
            $display("FAIL dis_erase got=%0d cycles %0d plots exp=47 cycles 16 plots", cyc, xs.size());
        end
        frame(objs, -10, '0);
        checks++;
        if (cyc !== 32) begin
            failures++;
            $display("FAIL dis_len got=%0d exp=32", cyc);
        end
        checks++;
        if (xs.size() !== 0) begin
            failures++;
            $display("FAIL dis_plots got=%0d exp=0", xs.size());
        end
    endtask

    task automatic test_back_to_back;
        frame(slot0(8'd10, 9'd20), 12, slot0(8'd50, 9'd200));
        checks++;
        if (cyc !== 47) begin
            failures++;
            $display("FAIL drop_len got=%0d exp=47", cyc);
        end
        checks++;
        if (xs.size() !== 16) begin
            failures++;
            $display("FAIL drop_count got=%0d exp=16", xs.size());
        end
        for (int i = 0; i < 16 && i < xs.size(); i++) begin
            checks++;
            if ({xs[i], ys[i]} !== {9'(20 + i % 4), 8'(10 + i / 4)}) begin
                failures++;
                $display("FAIL drop_pix%0d got=%0d,%0d exp=%0d,%0d", i, xs[i], ys[i], 20 + i % 4, 10 + i / 4);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int bg = 0;
        bus.objCoordcomb = slot0(8'd30, 9'd30);
        bus.imagedone = 1'b1;
        while (n < 200) begin
            @(posedge CLOCK_50);
            #1;
            n++;
            if (n == 3) bus.imagedone = 1'b0;
            if (bus.vga_plot && bus.vga_colour == 3'b100) break;
        end
        bus.imagedone = 1'b0;
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL mid_reach_draw got=%0d exp<200", n);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.vga_plot !== 1'b0) begin
            failures++;
            $display("FAIL mid_plot got=%b exp=0", bus.vga_plot);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_busy got=%b exp=0", busy);
        end
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        frame(slot0(8'd40, 9'd40), -10, '0);
        foreach (cs[i]) if (cs[i] == 3'b000) bg++;
        checks++;
        if (bg !== 0) begin
            failures++;
            $display("FAIL post_reset_erase got=%0d exp=0", bg);
        end
        checks++;
        if (cyc !== 47 || xs.size() !== 16) begin
            failures++;
            $display("FAIL post_reset_frame got=%0d cycles %0d plots exp=47 cycles 16 plots", cyc, xs.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_move();
        test_clip();
        test_collision();
        test_disabled();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/obj_frame_renderer.md
Name: obj_frame_renderer

Overview:
- Consumer end of the packed object bus `objCoordcomb` and the `imagedone` strobe driven by the game-object manipulator.
- On each `imagedone` rising edge it snapshots all 10 objects and erases the previous frame's squares from the 320x240 VGA adapter.
- It then plots the new squares one pixel per cycle and checks every enabled object against the player box.
- Its sticky `collision` output feeds the game controller's `gameover` logic.

Parameters:
- OBJ_SIZE, 4, side length in pixels of each object square; power of two, 2..8.
- PLAYER_SIZE, 16, side length in pixels of the player box used for the collision check.
- OBJ_COLOUR, 3'b100, colour plotted for objects.
- BG_COLOUR, 3'b000, colour plotted when erasing.

Ports:
- CLOCK_50  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- objCoordcomb  in  180  10 slots of 18 bits; slot n = bits [18n+17:18n]. Within a slot: bit 17 enable, [16:9] y, [8:0] x.
- imagedone  in  1  level from the manipulator; a rising edge means the coordinates are stable.
- playerX  in  9  player box top-left x.
- playerY  in  8  player box top-left y.
- clear_collision  in  1  synchronous clear of `collision`.
- vga_x  out  9  pixel x.
- vga_y  out  8  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe to the VGA adapter.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- collision  out  1  sticky overlap flag.

Behaviour:
- Reset (async, low): state IDLE.
  - `vga_plot`, `busy`, `frame_done`, `collision` = 0.
  - `vga_x`/`vga_y`/`vga_colour` = 0.
  - Old and new snapshot registers = 0 (all disabled).
  - `imagedone` edge register = 0.
- Edge detect: register `imagedone` each cycle; rise = current & ~previous.
- IDLE: on rise, latch `objCoordcomb` into NEW, go to ERASE with slot=0, px=py=0. Capture costs 1 cycle.
- Rises while `busy`=1 are dropped: no queueing, NEW is unchanged.
- ERASE: walk slots 0..9 of OLD.
  - Disabled slot: 1 cycle, `vga_plot`=0.
  - Enabled slot: OBJ_SIZE*OBJ_SIZE cycles, raster order with px fastest.
  - Each cycle presents `vga_x`=x+px, `vga_y`=y+py, `vga_colour`=BG_COLOUR.
  - `vga_plot`=1 unless clipped.
  - After slot 9, go to DRAW with slot=0.
- DRAW: same walk over NEW with OBJ_COLOUR, then go to CHECK.
- Clipping: a pixel with x+px >= 320 or y+py >= 240 still consumes its cycle but has `vga_plot`=0.
  - Sums are computed 10 bits wide; `vga_x`/`vga_y` carry the truncated low bits.
- CHECK: 10 cycles, one slot of NEW per cycle. An enabled slot overlaps when all four hold:
  - obj.x < playerX+PLAYER_SIZE
  - playerX < obj.x+OBJ_SIZE
  - obj.y < playerY+PLAYER_SIZE
  - playerY < obj.y+OBJ_SIZE
  - Compare in 10 bits unsigned. Any overlap sets `collision` on the next edge.
- DONE: 1 cycle. OLD <= NEW, `frame_done`=1, go to IDLE.
- Frame length with j enabled in OLD and k enabled in NEW:
  - 1 + (10 - j + j·OBJ_SIZE²) + (10 - k + k·OBJ_SIZE²) + 10 + 1 cycles.
- `collision`:
  - Stays set until `clear_collision` or reset.
  - `clear_collision` and a new overlap on the same edge: set wins.
- Outputs are registered; `vga_plot` is asserted in the same cycle as its coordinates.
- Reset mid-frame: `vga_plot` drops immediately and OLD is cleared. Stale pixels remain on screen; this is accepted, because the game restarts via the IDLE/INITIALIZE path anyway.
- Coordinates are not range-checked beyond clipping; x=320 objects plot nothing.

Test Plan:
- Reset, then one `imagedone` rise with slot0 = {1, y=10, x=20}, others 0 (OBJ_SIZE=4):
  - ERASE = 10 cycles, no plots.
  - Then 16 plots covering x 20..23 and y 10..13 in raster order, colour 3'b100.
  - `frame_done` pulses exactly 1+10+25+10+1 = 47 cycles after the rise.
- Second rise with slot0 x=21: first 16 plots are erases at x 20..23 with BG_COLOUR, then 16 draws at x 21..24; OLD now holds x=21.
- Clipping: slot0 = {1, y=238, x=318}. Exactly 4 pixels plotted, (318,238) (319,238) (318,239) (319,239); the other 12 cycles have `vga_plot`=0.
- Collision with player (100,100):
  - Object at (115,115) overlaps, so `collision`=1 after CHECK.
  - Object at (116,100) does not, so `collision`=0.
  - `clear_collision` pulse returns the flag to 0.
- Disabled-slot handling: all 10 slots with bit17=0 and x,y nonzero produce zero plots and a 32-cycle frame.
- Robustness:
  - An `imagedone` rise mid-DRAW is ignored; NEW is unchanged and the frame length is unchanged.
  - Reset asserted mid-DRAW gives `vga_plot`=0 and `busy`=0 asynchronously.
  - After reset, the next frame performs no erase plots.
